// File: rtl/fetch_mem_port_if.sv
// Memory bus between fetch_mem_port and unified memory.
//   master: drives mem_req/mem_we/mem_addr/mem_wdata, samples mem_ready/mem_rdata
//   slave : the memory side of the same handshake
// A request is held stable until the cycle mem_ready is high; mem_rdata is
// valid only when mem_req && mem_ready.
interface fetch_mem_port_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/fetch_mem_port.sv
// Instruction/data memory port for the multicycle RV32I core. Holds PC, OldPC,
// the instruction register and the load-data register, and arbitrates
// instruction fetches and loads/stores onto one ready-handshaked bus.
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   pc_write_i      load PC from result_i
//   ir_write_i      launch instruction fetch at PC (highest priority)
//   adr_src_i       must be 1 for mem_read_i / mem_write_i to launch
//   mem_read_i      launch load from data_adr_i
//   mem_write_i     launch store of wdata_i to data_adr_i
//   result_i        next-PC value
//   data_adr_i      load/store address
//   wdata_i         store data
//   mem             memory bus (master side)
//   pc_o, old_pc_o  current PC, PC of the instruction in instr_o
//   instr_o, data_o instruction register, load-data register
//   busy_o          access in flight, control must hold state
//   instr_fault_o   sticky misaligned-fetch flag
module fetch_mem_port #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pc_write_i,
    input  logic                     ir_write_i,
    input  logic                     adr_src_i,
    input  logic                     mem_read_i,
    input  logic                     mem_write_i,
    input  logic [31:0]              result_i,
    input  logic [31:0]              data_adr_i,
    input  logic [31:0]              wdata_i,
    fetch_mem_port_if.master         mem,
    output logic [31:0]              pc_o,
    output logic [31:0]              old_pc_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              data_o,
    output logic                     busy_o,
    output logic                     instr_fault_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_WAIT,
        DATA_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        done;

    // mem_ready outside an outstanding request carries no meaning.
    assign done = req_q && mem.mem_ready;

    always_comb begin
        state_d    = state_q;
        // PC update is independent of the access FSM; a fetch launched on the
        // same edge still uses pc_q.
        pc_d       = pc_write_i ? result_i : pc_q;
        old_pc_d   = old_pc_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        data_d     = data_q;
        fault_d    = fault_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (ir_write_i) begin
                    if (pc_q[1:0] == 2'b00) begin
                        addr_d     = pc_q;
                        we_d       = 1'b0;
                        req_d      = 1'b1;
                        fetch_pc_d = pc_q;
                        state_d    = FETCH_WAIT;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (adr_src_i && (mem_write_i || mem_read_i)) begin
                    addr_d  = data_adr_i;
                    we_d    = mem_write_i;
                    wdata_d = wdata_i;
                    req_d   = 1'b1;
                    state_d = DATA_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (done) begin
                    instr_d  = mem.mem_rdata;
                    old_pc_d = fetch_pc_q;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            DATA_WAIT: begin
                if (done) begin
                    if (!we_q) begin
                        data_d = mem.mem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            old_pc_q   <= '0;
            fetch_pc_q <= '0;
            instr_q    <= '0;
            data_q     <= '0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_pc_q   <= old_pc_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            fault_q    <= fault_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign pc_o          = pc_q;
    assign old_pc_o      = old_pc_q;
    assign instr_o       = instr_q;
    assign data_o        = data_q;
    assign busy_o        = (state_q != IDLE);
    assign instr_fault_o = fault_q;

endmodule

// File: tb/tb_fetch_mem_port.sv
// Self-checking bench for fetch_mem_port: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_fetch_mem_port;

    logic        clk;
    logic        rst_n;
    logic        pc_write, ir_write, adr_src, mem_read, mem_write;
    logic [31:0] result, data_adr, wdata;
    logic [31:0] pc, old_pc, instr, data;
    logic        busy, instr_fault;

    fetch_mem_port_if bif ();

    fetch_mem_port #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write_i    (pc_write),
        .ir_write_i    (ir_write),
        .adr_src_i     (adr_src),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .result_i      (result),
        .data_adr_i    (data_adr),
        .wdata_i       (wdata),
        .mem           (bif.master),
        .pc_o          (pc),
        .old_pc_o      (old_pc),
        .instr_o       (instr),
        .data_o        (data),
        .busy_o        (busy),
        .instr_fault_o (instr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:255];
    int unsigned wait_cfg;
    int unsigned cnt;
    logic        resp_ready, force_ready;
    logic [31:0] resp_rdata;

    assign bif.mem_ready = resp_ready | force_ready;
    assign bif.mem_rdata = resp_rdata;

    initial begin
        resp_ready = 1'b0;
        resp_rdata = '0;
        cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bif.mem_req === 1'b1) begin
                if (cnt >= wait_cfg) begin
                    resp_ready = 1'b1;
                    resp_rdata = mem[bif.mem_addr[9:2]];
                    if (bif.mem_we === 1'b1) mem[bif.mem_addr[9:2]] = bif.mem_wdata;
                    cnt = 0;
                end else begin
                    resp_ready = 1'b0;
                    cnt++;
                end
            end else begin
                resp_ready = 1'b0;
                cnt        = 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int unsigned n_checks;
    int unsigned n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        adr_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Called in the first cycle after a launch; counts busy cycles (bounded).
    task automatic wait_idle(output int unsigned n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:255];
    logic [31:0] e_pc, e_instr, e_old_pc, e_data;
    logic        e_fault;

    initial begin
        int unsigned n;
        logic [31:0] new_pc, a, w;
        int unsigned op;
        logic        with_pcw;

        n_checks    = 0;
        n_fail      = 0;
        force_ready = 1'b0;
        wait_cfg    = 0;
        result      = '0;
        data_adr    = '0;
        wdata       = '0;
        clear_ctl();
        for (int unsigned i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h40] = 32'h0050_0093;
        rst_n = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_pc",     pc,            32'h100);
        chk("rst_busy",   busy,          0);
        chk("rst_req",    bif.mem_req,   0);
        chk("rst_we",     bif.mem_we,    0);
        chk("rst_addr",   bif.mem_addr,  0);
        chk("rst_wdata",  bif.mem_wdata, 0);
        chk("rst_oldpc",  old_pc,        0);
        chk("rst_instr",  instr,         0);
        chk("rst_data",   data,          0);
        chk("rst_fault",  instr_fault,   0);
        rst_n = 1'b1;
        tick();

        // first fetch, zero wait states
        wait_cfg = 0;
        ir_write = 1'b1;
        tick();
        clear_ctl();
        chk("f1_req",  bif.mem_req,  1);
        chk("f1_addr", bif.mem_addr, 32'h100);
        chk("f1_we",   bif.mem_we,   0);
        wait_idle(n);
        chk("f1_busy_cycles", n, 1);
        chk("f1_instr",  instr,       32'h0050_0093);
        chk("f1_oldpc",  old_pc,      32'h100);
        chk("f1_req_off", bif.mem_req, 0);

        // same-edge fetch + pc_write, 3 wait cycles
        mem[8'h40] = 32'h00A0_0113;
        wait_cfg = 3;
        ir_write = 1'b1;
        pc_write = 1'b1;
        result   = 32'h104;
        tick();
        clear_ctl();
        chk("f2_pc",   pc,           32'h104);
        chk("f2_addr", bif.mem_addr, 32'h100);
        wait_idle(n);
        chk("f2_busy_cycles", n, 4);
        chk("f2_instr", instr,  32'h00A0_0113);
        chk("f2_oldpc", old_pc, 32'h100);

        // load with 2 wait cycles
        mem[8'h00] = 32'hDEAD_BEEF;
        wait_cfg = 2;
        adr_src  = 1'b1;
        mem_read = 1'b1;
        data_adr = 32'h2000;
        tick();
        clear_ctl();
        chk("ld_we",   bif.mem_we,   0);
        chk("ld_addr", bif.mem_addr, 32'h2000);
        wait_idle(n);
        chk("ld_busy_cycles", n, 3);
        chk("ld_data",  data,  32'hDEAD_BEEF);
        chk("ld_instr", instr, 32'h00A0_0113);

        // store held together with ir_write: fetch first, store relaunched after
        mem[8'h41] = 32'h0020_8193;
        wait_cfg  = 1;
        ir_write  = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        data_adr  = 32'h2004;
        wdata     = 32'hCAFE_F00D;
        tick();
        ir_write = 1'b0;
        chk("st_fetch_we",   bif.mem_we,   0);
        chk("st_fetch_addr", bif.mem_addr, 32'h104);
        wait_idle(n);
        chk("st_fetch_cycles", n, 2);
        chk("st_instr", instr,  32'h0020_8193);
        chk("st_oldpc", old_pc, 32'h104);
        tick();
        clear_ctl();
        chk("st_req",   bif.mem_req,   1);
        chk("st_we",    bif.mem_we,    1);
        chk("st_addr",  bif.mem_addr,  32'h2004);
        chk("st_wdata", bif.mem_wdata, 32'hCAFE_F00D);
        wait_idle(n);
        chk("st_cycles", n, 2);
        chk("st_mem",    mem[8'h01], 32'hCAFE_F00D);
        chk("st_data_keep", data, 32'hDEAD_BEEF);

        // misaligned fetch
        pc_write = 1'b1;
        result   = 32'h102;
        tick();
        clear_ctl();
        chk("mis_pc", pc, 32'h102);
        ir_write = 1'b1;
        tick();
        clear_ctl();
        chk("mis_req",   bif.mem_req, 0);
        chk("mis_busy",  busy,        0);
        chk("mis_fault", instr_fault, 1);
        chk("mis_instr", instr,       32'h0020_8193);
        pc_write = 1'b1;
        result   = 32'h100;
        tick();
        clear_ctl();
        ir_write = 1'b1;
        tick();
        clear_ctl();
        wait_idle(n);
        chk("mis_sticky", instr_fault, 1);

        // reset during FETCH_WAIT
        wait_cfg = 5;
        ir_write = 1'b1;
        tick();
        clear_ctl();
        chk("rf_busy", busy, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rf_req",   bif.mem_req, 0);
        chk("rf_busy0", busy,        0);
        chk("rf_pc",    pc,          32'h100);
        chk("rf_instr", instr,       0);
        chk("rf_fault", instr_fault, 0);
        tick();
        rst_n       = 1'b1;
        force_ready = 1'b1;
        tick();
        tick();
        force_ready = 1'b0;
        chk("rf_late_instr", instr,       0);
        chk("rf_late_busy",  busy,        0);
        chk("rf_late_req",   bif.mem_req, 0);

        // ---------------- randomized transactions ----------------
        for (int unsigned i = 0; i < 256; i++) ref_mem[i] = mem[i];
        e_pc = 32'h100; e_instr = '0; e_old_pc = '0; e_data = '0; e_fault = 1'b0;

        for (int unsigned it = 0; it < 80; it++) begin
            op       = $urandom_range(0, 4);
            wait_cfg = $urandom_range(0, 3);
            case (op)
                0: begin // fetch, sometimes with simultaneous pc_write
                    with_pcw = $urandom_range(0, 1) == 1;
                    new_pc   = {22'd0, 8'($urandom), 2'b00};
                    ir_write = 1'b1;
                    pc_write = with_pcw;
                    result   = new_pc;
                    tick();
                    clear_ctl();
                    if (e_pc[1:0] != 2'b00) begin
                        e_fault = 1'b1;
                        chk("r_mis_busy", busy, 0);
                    end else begin
                        chk("r_f_addr", bif.mem_addr, e_pc);
                        chk("r_f_we",   bif.mem_we,   0);
                        wait_idle(n);
                        chk("r_f_cycles", n, wait_cfg + 1);
                        e_instr  = ref_mem[e_pc[9:2]];
                        e_old_pc = e_pc;
                    end
                    if (with_pcw) e_pc = new_pc;
                end
                1, 2: begin // load / store
                    a        = {22'd0, 8'($urandom), 2'b00};
                    w        = $urandom;
                    adr_src  = 1'b1;
                    mem_read = (op == 1);
                    mem_write = (op == 2);
                    data_adr = a;
                    wdata    = w;
                    tick();
                    clear_ctl();
                    chk("r_d_addr", bif.mem_addr, a);
                    chk("r_d_we",   bif.mem_we,   (op == 2) ? 1 : 0);
                    wait_idle(n);
                    chk("r_d_cycles", n, wait_cfg + 1);
                    if (op == 1) e_data = ref_mem[a[9:2]];
                    else         ref_mem[a[9:2]] = w;
                end
                3: begin // pc_write only, occasionally misaligned
                    new_pc = {22'd0, 8'($urandom), 2'b00};
                    if ($urandom_range(0, 7) == 0) new_pc[1] = 1'b1;
                    pc_write = 1'b1;
                    result   = new_pc;
                    tick();
                    clear_ctl();
                    e_pc = new_pc;
                end
                default: begin // data request without adr_src: ignored
                    mem_read  = $urandom_range(0, 1) == 1;
                    mem_write = !mem_read;
                    data_adr  = $urandom;
                    tick();
                    clear_ctl();
                    chk("r_noadr_busy", busy, 0);
                end
            endcase
            chk("r_pc",     pc,          e_pc);
            chk("r_instr",  instr,       e_instr);
            chk("r_oldpc",  old_pc,      e_old_pc);
            chk("r_data",   data,        e_data);
            chk("r_fault",  instr_fault, {31'd0, e_fault});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
